// File: rtl/gl_decode.sv
// rtl/gl_decode.sv - GL command operand-gathering decode stage
//
// Takes one instruction word from fetch. It decodes the operand count from the
// opcode and reads that many trailing operand words from command memory. It then
// offers the complete command to the back end over a valid/ready handshake.
//
// Ports:
//   clk, reset      pipeline clock, asynchronous active-high reset
//   inst_in         instruction word from fetch, opcode in [7:0]
//   inst_addr_in    byte address of inst_in
//   inst_valid      inst_in/inst_addr_in valid
//   stall           hold fetch (high whenever not idle)
//   bram_en         operand read enable
//   bram_addr       operand byte address
//   bram_data       read data, valid one cycle after bram_en
//   cmd_valid       command available
//   cmd_ready       back end accepts the command
//   cmd_opcode      opcode of the held command
//   cmd_count       number of valid operands (0..16)
//   cmd_addr        byte address of the command's instruction word
//   op_rd_idx       operand select
//   op_rd_data      operand buffer entry op_rd_idx (combinational)

module gl_decode #(
   parameter int width   = 32,
   parameter int max_ops = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [width-1:0] inst_in,
   input  logic [width-1:0] inst_addr_in,
   input  logic             inst_valid,
   output logic             stall,
   output logic             bram_en,
   output logic [width-1:0] bram_addr,
   input  logic [width-1:0] bram_data,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [7:0]       cmd_opcode,
   output logic [4:0]       cmd_count,
   output logic [width-1:0] cmd_addr,
   input  logic [3:0]       op_rd_idx,
   output logic [width-1:0] op_rd_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_HOLD
   } state_t;

   state_t           state_q;
   logic [7:0]       opcode_q;
   logic [4:0]       count_q;
   logic [width-1:0] addr_q;
   logic [width-1:0] rd_addr_q;
   logic [4:0]       k_q;
   logic             rd_pend_q;
   logic [3:0]       rd_idx_q;
   logic [width-1:0] buf_q [max_ops];

   logic [4:0]       dec_n;
   logic             dec_nop;

   // Only the opcode byte carries meaning for this stage.
   logic             unused_inst_bits;
   assign unused_inst_bits = ^inst_in[width-1:8];

   always_comb begin
      dec_n   = 5'd0;
      dec_nop = 1'b0;
      case (inst_in[7:0])
         8'h00:                             dec_nop = 1'b1;
         8'h03, 8'h04:                      dec_n   = 5'd3;
         8'h11, 8'h13, 8'h16, 8'h17, 8'h18: dec_n   = 5'd16;
         8'h19:                             dec_n   = 5'd4;
         8'h1A:                             dec_n   = 5'd6;
         default:                           dec_n   = 5'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         opcode_q  <= 8'd0;
         count_q   <= 5'd0;
         addr_q    <= '0;
         rd_addr_q <= '0;
         k_q       <= 5'd0;
         rd_pend_q <= 1'b0;
         rd_idx_q  <= 4'd0;
         for (int i = 0; i < max_ops; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         // Read data lands one cycle after its enable; rd_pend_q/rd_idx_q
         // remember which slot the returning word belongs to.
         rd_pend_q <= 1'b0;
         if (rd_pend_q) begin
            buf_q[rd_idx_q] <= bram_data;
         end

         case (state_q)
            S_IDLE: begin
               if (inst_valid && !dec_nop) begin
                  opcode_q  <= inst_in[7:0];
                  count_q   <= dec_n;
                  addr_q    <= inst_addr_in;
                  k_q       <= 5'd0;
                  rd_addr_q <= inst_addr_in + width'(4);
                  state_q   <= (dec_n == 5'd0) ? S_HOLD : S_READ;
               end
            end
            S_READ: begin
               rd_pend_q <= 1'b1;
               rd_idx_q  <= k_q[3:0];
               if (k_q == count_q - 5'd1) begin
                  state_q <= S_DRAIN;
               end else begin
                  k_q       <= k_q + 5'd1;
                  rd_addr_q <= rd_addr_q + width'(4);
               end
            end
            S_DRAIN: begin
               // The last operand is captured by the rd_pend_q path above.
               state_q <= S_HOLD;
            end
            S_HOLD: begin
               if (cmd_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign stall      = (state_q != S_IDLE);
   assign bram_en    = (state_q == S_READ);
   assign bram_addr  = rd_addr_q;
   assign cmd_valid  = (state_q == S_HOLD);
   assign cmd_opcode = opcode_q;
   assign cmd_count  = count_q;
   assign cmd_addr   = addr_q;
   assign op_rd_data = buf_q[op_rd_idx];

endmodule

// File: tb/tb_gl_decode.sv
// tb/tb_gl_decode.sv - self-checking bench for gl_decode
`timescale 1ns/1ps

module tb_gl_decode;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst_in;
   logic [31:0] inst_addr_in;
   logic        inst_valid;
   logic        stall;
   logic        bram_en;
   logic [31:0] bram_addr;
   logic [31:0] bram_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [4:0]  cmd_count;
   logic [31:0] cmd_addr;
   logic [3:0]  op_rd_idx;
   logic [31:0] op_rd_data;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [logic [31:0]];
   int unsigned n_tab [logic [7:0]];

   gl_decode #(.width(32), .max_ops(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .inst_in      (inst_in),
      .inst_addr_in (inst_addr_in),
      .inst_valid   (inst_valid),
      .stall        (stall),
      .bram_en      (bram_en),
      .bram_addr    (bram_addr),
      .bram_data    (bram_data),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_opcode   (cmd_opcode),
      .cmd_count    (cmd_count),
      .cmd_addr     (cmd_addr),
      .op_rd_idx    (op_rd_idx),
      .op_rd_data   (op_rd_data)
   );

   always #50 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (!mem.exists(a)) mem[a] = $urandom;
      return mem[a];
   endfunction

   function automatic int op_count(input logic [7:0] op);
      return n_tab.exists(op) ? int'(n_tab[op]) : 0;
   endfunction

   // Command memory: one-cycle read latency, garbage when not enabled.
   always @(posedge clk) begin
      bram_data <= bram_en ? mem_rd(bram_addr) : 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      inst_valid = 1'b0;
      inst_in    = $urandom;
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge with the design idle. Drives one instruction and
   // checks every cycle up to and including the return to idle. hold = 0
   // means cmd_ready is already high; otherwise ready stays low for hold-1
   // HOLD cycles and rises in the last one.
   task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input int hold);
      int          n;
      int          hold_cyc;
      logic [31:0] exp_op [16];
      n        = op_count(op);
      hold_cyc = (hold == 0) ? 1 : hold;
      check("idle_stall", {31'd0, stall}, 32'd0);
      inst_in      = ($urandom & 32'hFFFF_FF00) | {24'd0, op};
      inst_addr_in = addr;
      inst_valid   = 1'b1;
      cmd_ready    = (hold == 0);
      @(negedge clk);
      if (op == 8'h00) begin
         check("nop_stall", {31'd0, stall}, 32'd0);
         check("nop_valid", {31'd0, cmd_valid}, 32'd0);
         return;
      end
      for (int j = 1; j <= n; j++) begin
         check("rd_en",    {31'd0, bram_en},   32'd1);
         check("rd_addr",  bram_addr,          addr + 32'(4 * j));
         check("rd_stall", {31'd0, stall},     32'd1);
         check("rd_valid", {31'd0, cmd_valid}, 32'd0);
         @(negedge clk);
      end
      if (n > 0) begin
         check("drain_en",    {31'd0, bram_en},   32'd0);
         check("drain_valid", {31'd0, cmd_valid}, 32'd0);
         check("drain_stall", {31'd0, stall},     32'd1);
         @(negedge clk);
      end
      for (int k = 0; k < n; k++) exp_op[k] = mem_rd(addr + 32'(4 * (k + 1)));
      for (int h = 0; h < hold_cyc; h++) begin
         check("hold_valid",  {31'd0, cmd_valid}, 32'd1);
         check("hold_stall",  {31'd0, stall},     32'd1);
         check("hold_en",     {31'd0, bram_en},   32'd0);
         check("hold_opcode", {24'd0, cmd_opcode}, {24'd0, op});
         check("hold_count",  {27'd0, cmd_count},  32'(n));
         check("hold_addr",   cmd_addr, addr);
         if (h == 0 || h == hold_cyc - 1) begin
            for (int k = 0; k < n; k++) begin
               op_rd_idx = 4'(k);
               #1;
               check($sformatf("operand%0d", k), op_rd_data, exp_op[k]);
            end
         end
         if (h == hold_cyc - 1) cmd_ready = 1'b1;
         @(negedge clk);
      end
      check("done_stall", {31'd0, stall},     32'd0);
      check("done_valid", {31'd0, cmd_valid}, 32'd0);
   endtask

   initial begin
      logic [7:0] ops [11];
      n_tab[8'h03] = 3;  n_tab[8'h04] = 3;
      n_tab[8'h11] = 16; n_tab[8'h13] = 16; n_tab[8'h16] = 16;
      n_tab[8'h17] = 16; n_tab[8'h18] = 16;
      n_tab[8'h19] = 4;  n_tab[8'h1A] = 6;
      ops = '{8'h00, 8'h03, 8'h04, 8'h11, 8'h13, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h2B};

      reset        = 1'b1;
      inst_in      = 32'd0;
      inst_addr_in = 32'd0;
      inst_valid   = 1'b0;
      cmd_ready    = 1'b0;
      op_rd_idx    = 4'd0;
      repeat (2) @(negedge clk);
      check("rst_stall",  {31'd0, stall},     32'd0);
      check("rst_en",     {31'd0, bram_en},   32'd0);
      check("rst_valid",  {31'd0, cmd_valid}, 32'd0);
      check("rst_baddr",  bram_addr,          32'd0);
      check("rst_count",  {27'd0, cmd_count}, 32'd0);
      check("rst_buf0",   op_rd_data,         32'd0);
      reset = 1'b0;
      @(negedge clk);

      // VERTEX with known operands
      mem[32'h104] = 32'd1; mem[32'h108] = 32'd2; mem[32'h10C] = 32'd3;
      run_cmd(8'h03, 32'h100, 0);
      idle(2);

      // LOADMATRIX, back end stalls in HOLD
      for (int k = 0; k < 16; k++) mem[32'(4 * (k + 1))] = 32'hA0 + 32'(k);
      run_cmd(8'h13, 32'h0, 11);
      idle(1);

      // NOP then pass-through opcode
      run_cmd(8'h00, 32'h200, 0);
      run_cmd(8'h05, 32'h204, 0);
      idle(1);

      // Address wrap
      run_cmd(8'h1A, 32'hFFFF_FFF0, 2);
      idle(1);

      // Asynchronous reset during the 5th read of MULTMATRIX
      inst_in = 32'h11; inst_addr_in = 32'h2000; inst_valid = 1'b1; cmd_ready = 1'b1;
      @(negedge clk);
      for (int j = 1; j < 5; j++) @(negedge clk);
      check("pre_rst_addr", bram_addr, 32'h2014);
      #10 reset = 1'b1;
      #1;
      check("arst_stall", {31'd0, stall},      32'd0);
      check("arst_en",    {31'd0, bram_en},    32'd0);
      check("arst_valid", {31'd0, cmd_valid},  32'd0);
      check("arst_baddr", bram_addr,           32'd0);
      check("arst_op",    {24'd0, cmd_opcode}, 32'd0);
      check("arst_count", {27'd0, cmd_count},  32'd0);
      check("arst_caddr", cmd_addr,            32'd0);
      for (int k = 0; k < 16; k++) begin
         op_rd_idx = 4'(k);
         #1;
         check("arst_buf", op_rd_data, 32'd0);
      end
      inst_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_cmd(8'h03, 32'h100, 0);

      // Back-to-back with inst_valid held
      run_cmd(8'h19, 32'h3000, 0);
      run_cmd(8'h03, 32'h3014, 0);
      idle(1);

      // Randomized commands
      for (int i = 0; i < 30; i++) begin
         logic [7:0] op;
         op = ops[$urandom_range(0, 10)];
         if (op == 8'h2B) op = 8'($urandom_range(0, 255));
         run_cmd(op, $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)));
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/gl_decode.md
# gl_decode

Operand-gathering decode stage directly downstream of the instruction fetch stage in the GL command pipeline. Accepts one instruction word per command, reads that command's trailing operand words from the command BRAM over a dedicated read port, and buffers them. It then presents a complete command (opcode, operand count, operands) to the transform/raster back end over a valid/ready handshake. It asserts `stall` back to fetch while gathering or while the back end is not ready.

## Interface
- `width`, 32, data and address width
- `max_ops`, 16, operand buffer depth in words; must be at least 16

- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high reset
- `inst_in`  in  width  instruction word from fetch; opcode in `[7:0]`
- `inst_addr_in`  in  width  byte address of `inst_in` in command memory
- `inst_valid`  in  1  `inst_in`/`inst_addr_in` valid this cycle
- `stall`  out  1  hold fetch; fetch must keep `inst_in` stable while high
- `bram_en`  out  1  operand read enable
- `bram_addr`  out  width  operand byte address, word-aligned
- `bram_data`  in  width  read data, valid exactly one cycle after `bram_en`
- `cmd_valid`  out  1  command available
- `cmd_ready`  in  1  back end accepts the command
- `cmd_opcode`  out  8  opcode of the held command
- `cmd_count`  out  5  number of valid operands, 0..16
- `cmd_addr`  out  width  byte address of the command's instruction word
- `op_rd_idx`  in  4  operand select
- `op_rd_data`  out  width  `buf[op_rd_idx]`, combinational

## Operation
- The operand count N is decoded from `inst_in[7:0]`:
  - 0x03 VERTEX, 0x04 COLOR: N=3
  - 0x11 MULTMATRIX, 0x13 LOADMATRIX, 0x16 ROTATE, 0x17 SCALE, 0x18 TRANSLATE: N=16
  - 0x19 VIEWPORT: N=4
  - 0x1A FRUSTUM: N=6
  - 0x00 NOP: dropped, no command issued
  - any other opcode: N=0, passed through as a command
- Operand k (k=0..N-1) is read from `cmd_addr + 4*(k+1)`. Address arithmetic is modulo 2^width and wraps silently.
- FSM states:
  - IDLE: `stall`=0.
    - `inst_valid` and NOP: stay in IDLE.
    - `inst_valid` and N>0: latch opcode, address and N; go to READ.
    - `inst_valid` and N=0: latch; go to HOLD.
  - READ: one `bram_en` pulse per cycle, k = 0..N-1, back-to-back. Data returned the following cycle is written to `buf[k]`. After issuing k=N-1, go to DRAIN.
  - DRAIN: `bram_en`=0; capture `buf[N-1]`; go to HOLD.
  - HOLD: `cmd_valid`=1. When `cmd_ready`=1, go to IDLE.
- `stall` = (state != IDLE). It is registered-state-derived only and never depends combinationally on `cmd_ready`.
- `cmd_opcode`, `cmd_count`, `cmd_addr` and the buffer stay stable throughout HOLD.
- `buf` entries at index ≥ `cmd_count` hold stale data. Consumers must ignore them.
- `inst_valid` is ignored outside IDLE.

## Timing
- Instruction accepted at edge T (IDLE):
  - `bram_en` high T+1..T+N
  - last data captured at edge T+N+1
  - `cmd_valid` high from T+N+1
- Command latency: N+1 cycles from accept to `cmd_valid`. For N=0, `cmd_valid` rises 1 cycle after accept.
- Handshake completes at the first edge where `cmd_valid` and `cmd_ready` are both high. `stall` falls in the same cycle the state returns to IDLE. The next instruction can be accepted at the following edge.
- Minimum spacing between commands is N+3 cycles at full `cmd_ready` (N=16 gives 19).
- `cmd_ready` may be high before `cmd_valid`. It has no effect outside HOLD.
- Asynchronous reset, effective at any state including mid-READ:
  - state goes to IDLE
  - `stall`, `bram_en`, `cmd_valid` = 0
  - `bram_addr`, `cmd_opcode`, `cmd_count`, `cmd_addr` = 0
  - all `buf` entries = 0
  - read data in flight when reset deasserts is discarded

## Test plan
- VERTEX (0x03) at 0x100, BRAM 0x104/0x108/0x10C = 1,2,3, `cmd_ready`=1:
  - `bram_addr` 0x104, 0x108, 0x10C on consecutive cycles
  - `cmd_valid` 4 cycles after accept, `cmd_count`=3, `op_rd_data`[0..2]=1,2,3
  - `stall` high for exactly 5 cycles
- LOADMATRIX (0x13) at 0x0, words 0x4..0x40 = 0xA0..0xAF, `cmd_ready` held low 10 cycles in HOLD:
  - 16 back-to-back reads
  - `cmd_valid` and all outputs stable for 10 cycles
  - `stall` stays high until the handshake completes
- NOP (0x00) followed by opcode 0x05:
  - NOP produces no `cmd_valid` and no stall
  - 0x05 gives `cmd_count`=0 and `cmd_valid` 1 cycle after accept
- FRUSTUM (0x1A) at 0xFFFFFFF0:
  - read addresses 0xFFFFFFF4, 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8 (wrap)
  - `cmd_count`=6
- `reset` asserted asynchronously during the 5th read of MULTMATRIX:
  - all outputs go to 0 immediately, state IDLE
  - after release, a VERTEX completes normally with correct operands
- Back-to-back VIEWPORT (0x19) then VERTEX (0x03) with `inst_valid` held, `cmd_ready`=1:
  - VERTEX is accepted on the edge after VIEWPORT's handshake
  - second command's `cmd_addr` and operands are correct
